// File: rtl/ysyx_22050535_npc_pkg.sv
// Shared constants and types for the ysyx_22050535 multi-cycle NPC.
// Opcodes, FSM states, halt causes and a register-index check.
package ysyx_22050535_npc_pkg;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [2:0] F3_ADDI  = 3'b000;
  localparam logic [2:0] F3_JALR  = 3'b000;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  typedef enum logic [1:0] {
    FETCH_REQ,
    FETCH_WAIT,
    EXEC,
    HALT
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_EBREAK   = 2'b00,
    CAUSE_ILLEGAL  = 2'b01,
    CAUSE_FETCH    = 2'b10,
    CAUSE_MISALIGN = 2'b11
  } cause_t;

  function automatic logic reg_ok(input logic [4:0] idx, input int n);
    return int'(idx) < n;
  endfunction

endpackage

// File: rtl/ysyx_22050535_regfile_p.sv
// Parametrised register file: two async reads, one sync write.
// Entry 0 is never written and always reads as zero.
module ysyx_22050535_regfile_p #(
  parameter int XLEN    = 32,
  parameter int NR_REGS = 32,
  localparam int AW     = $clog2(NR_REGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   ra_addr,
  output logic [XLEN-1:0] ra_data,
  input  logic [AW-1:0]   rb_addr,
  output logic [XLEN-1:0] rb_data,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [NR_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR_REGS; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  assign ra_data = (ra_addr == '0) ? '0 : regs[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 : regs[rb_addr];

endmodule

// File: rtl/ysyx_22050535_npc_mc.sv
// Multi-cycle NPC core: valid/ready fetch, one-cycle execute.
// Supports ADDI/LUI/AUIPC/JAL/JALR/EBREAK; halts on faults.
module ysyx_22050535_npc_mc
  import ysyx_22050535_npc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NR_REGS  = 32,
  parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ifu_req_valid,
  input  logic            ifu_req_ready,
  output logic [XLEN-1:0] ifu_req_addr,
  input  logic            ifu_rsp_valid,
  output logic            ifu_rsp_ready,
  input  logic [31:0]     ifu_rsp_inst,
  input  logic            ifu_rsp_err,
  output logic [XLEN-1:0] pc,
  output logic            commit_valid,
  output logic [XLEN-1:0] commit_pc,
  output logic            halt,
  output logic [1:0]      halt_cause,
  output logic [XLEN-1:0] halt_code
);

  localparam int AW = $clog2(NR_REGS);

  state_t state, state_n;
  cause_t cause_q, cause_n;
  logic [31:0] ir;

  logic [6:0] opc;
  logic [4:0] rd, rs1;
  logic [2:0] f3;
  logic signed [11:0] si;
  logic signed [31:0] su;
  logic signed [20:0] sj;
  logic [XLEN-1:0] imm_i, imm_u, imm_j;
  logic [XLEN-1:0] rs1_val, a0_val, pc_4, res, npc;
  logic is_ebreak, wr, illegal, misalign, stop;

  assign opc = ir[6:0];
  assign rd  = ir[11:7];
  assign f3  = ir[14:12];
  assign rs1 = ir[19:15];

  assign si    = ir[31:20];
  assign su    = {ir[31:12], 12'b0};
  assign sj    = {ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign imm_i = XLEN'(si);
  assign imm_u = XLEN'(su);
  assign imm_j = XLEN'(sj);
  assign pc_4  = pc + XLEN'(4);

  // Port B permanently watches a0 so halt_code can be sampled any cycle.
  ysyx_22050535_regfile_p #(
    .XLEN    (XLEN),
    .NR_REGS (NR_REGS)
  ) u_rf (
    .clk     (clk),
    .rst_n   (rst),
    .ra_addr (rs1[AW-1:0]),
    .ra_data (rs1_val),
    .rb_addr (AW'(10)),
    .rb_data (a0_val),
    .we      (commit_valid && wr && rd != 5'd0),
    .wa      (rd[AW-1:0]),
    .wd      (res)
  );

  always_comb begin
    is_ebreak = 1'b0;
    wr        = 1'b0;
    illegal   = 1'b0;
    res       = '0;
    npc       = pc_4;
    unique case (1'b1)
      ir == EBREAK_INST: is_ebreak = 1'b1;
      opc == OP_IMM && f3 == F3_ADDI: begin
        wr      = 1'b1;
        res     = rs1_val + imm_i;
        illegal = !reg_ok(rs1, NR_REGS) || !reg_ok(rd, NR_REGS);
      end
      opc == OP_LUI: begin
        wr      = 1'b1;
        res     = imm_u;
        illegal = !reg_ok(rd, NR_REGS);
      end
      opc == OP_AUIPC: begin
        wr      = 1'b1;
        res     = pc + imm_u;
        illegal = !reg_ok(rd, NR_REGS);
      end
      opc == OP_JAL: begin
        wr      = 1'b1;
        res     = pc_4;
        npc     = pc + imm_j;
        illegal = !reg_ok(rd, NR_REGS);
      end
      opc == OP_JALR && f3 == F3_JALR: begin
        wr      = 1'b1;
        res     = pc_4;
        npc     = (rs1_val + imm_i) & ~XLEN'(1);
        illegal = !reg_ok(rs1, NR_REGS) || !reg_ok(rd, NR_REGS);
      end
      default: illegal = 1'b1;
    endcase
  end

  assign misalign = (opc == OP_JAL || opc == OP_JALR) && npc[1];
  assign stop     = is_ebreak || illegal || misalign;

  always_comb begin
    state_n       = state;
    ifu_req_valid = 1'b0;
    ifu_rsp_ready = 1'b0;
    commit_valid  = 1'b0;
    cause_n       = CAUSE_EBREAK;
    unique case (state)
      FETCH_REQ: begin
        ifu_req_valid = 1'b1;
        if (ifu_req_ready) state_n = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        ifu_rsp_ready = 1'b1;
        cause_n       = CAUSE_FETCH;
        if (ifu_rsp_valid) state_n = ifu_rsp_err ? HALT : EXEC;
      end
      EXEC: begin
        commit_valid = !illegal && !misalign;
        state_n      = stop ? HALT : FETCH_REQ;
        if (illegal)       cause_n = CAUSE_ILLEGAL;
        else if (misalign) cause_n = CAUSE_MISALIGN;
      end
      HALT: state_n = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH_REQ;
    else      state <= state_n;
  end

  // Ebreak leaves pc pointing at itself for the harness.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RESET_PC;
      ir        <= '0;
      cause_q   <= CAUSE_EBREAK;
      halt_code <= '0;
    end else begin
      if (ifu_rsp_ready && ifu_rsp_valid && !ifu_rsp_err) ir <= ifu_rsp_inst;
      if (commit_valid && !is_ebreak) pc <= npc;
      if (state != HALT && state_n == HALT) begin
        cause_q   <= cause_n;
        halt_code <= a0_val;
      end
    end
  end

  assign ifu_req_addr = pc;
  assign commit_pc    = pc;
  assign halt         = (state == HALT);
  assign halt_cause   = cause_q;

endmodule
